// File: rtl/pktunit_axis_arbiter_if.sv
// Bundle of pktunit AXI-Stream lanes (data, flags, eop sharing one valid/ready per lane).
// One instance carries every source lane; another carries the single merged output lane.
interface pktunit_axis_arbiter_if #(
  parameter int DATA_BYTES = 8,
  parameter int LANES      = 1
);
  logic [LANES*DATA_BYTES*8-1:0] data_d;
  logic [LANES*8-1:0]            flags_d;
  logic [LANES*DATA_BYTES-1:0]   eop_d;
  logic [LANES-1:0]              data_v;
  logic [LANES-1:0]              flags_v;
  logic [LANES-1:0]              eop_v;
  logic [LANES-1:0]              data_r;
  logic [LANES-1:0]              flags_r;
  logic [LANES-1:0]              eop_r;

  modport master (
    output data_d, flags_d, eop_d, data_v, flags_v, eop_v,
    input  data_r, flags_r, eop_r
  );

  modport slave (
    input  data_d, flags_d, eop_d, data_v, flags_v, eop_v,
    output data_r, flags_r, eop_r
  );
endinterface

// File: rtl/pktunit_axis_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS pktunit streams into one registered stream.
// A granted packet is forwarded beat-for-beat until its eop beat; ports are never interleaved.
module pktunit_axis_arbiter #(
  parameter int  DATA_BYTES = 8,
  parameter int  NUM_PORTS  = 4,
  localparam int GW         = $clog2(NUM_PORTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  pktunit_axis_arbiter_if.slave  s,
  pktunit_axis_arbiter_if.master m,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic [31:0]            pkt_count
);

  localparam int DW = DATA_BYTES * 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  state_t                next_state;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  s_ready;
  logic                  m_ready;
  logic                  m_v;
  logic                  can_load;
  logic                  accept;
  logic                  last;
  logic                  pick_valid;
  logic [GW-1:0]         pick_id;
  logic [DW-1:0]         sel_data;
  logic [7:0]            sel_flags;
  logic [DATA_BYTES-1:0] sel_eop;
  logic [DW-1:0]         m_data_q;
  logic [7:0]            m_flags_q;
  logic [DATA_BYTES-1:0] m_eop_q;

  assign req       = s.data_v & s.flags_v & s.eop_v;
  assign m_ready   = m.data_r[0] & m.flags_r[0] & m.eop_r[0];
  assign can_load  = !m_v || m_ready;
  assign sel_data  = s.data_d[grant_id*DW +: DW];
  assign sel_flags = s.flags_d[grant_id*8 +: 8];
  assign sel_eop   = s.eop_d[grant_id*DATA_BYTES +: DATA_BYTES];
  assign last      = |sel_eop;
  assign accept    = (state == XFER) && req[grant_id] && can_load;
  assign busy      = (state == XFER);

  assign s.data_r  = s_ready;
  assign s.flags_r = s_ready;
  assign s.eop_r   = s_ready;

  assign m.data_d  = m_data_q;
  assign m.flags_d = m_flags_q;
  assign m.eop_d   = m_eop_q;
  assign m.data_v  = m_v;
  assign m.flags_v = m_v;
  assign m.eop_v   = m_v;

  // Scan from the farthest offset down so the nearest requester after grant_id wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = grant_id;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(grant_id) + k) % NUM_PORTS;
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_ready    = '0;
    case (state)
      IDLE: begin
        if (pick_valid) next_state = XFER;
      end
      XFER: begin
        s_ready[grant_id] = can_load;
        if (accept && last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single-entry output register; an accept in the same cycle as an output fire refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id  <= GW'(NUM_PORTS - 1);
      m_v       <= 1'b0;
      m_data_q  <= '0;
      m_flags_q <= '0;
      m_eop_q   <= '0;
      pkt_count <= '0;
    end else begin
      if (state == IDLE && pick_valid) grant_id <= pick_id;
      if (accept) begin
        m_data_q  <= sel_data;
        m_flags_q <= sel_flags;
        m_eop_q   <= sel_eop;
        m_v       <= 1'b1;
        if (last) pkt_count <= pkt_count + 32'd1;
      end else if (m_v && m_ready) begin
        m_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pktunit_axis_arbiter.sv
// Scoreboard bench for pktunit_axis_arbiter: per-port source queues feed the DUT,
// expected beats are queued in predicted grant order and popped as the output fires.
module tb_pktunit_axis_arbiter;

  localparam int DATA_BYTES = 8;
  localparam int NUM_PORTS  = 4;
  localparam int GW         = 2;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  flags;
    logic [7:0]  eop;
    int          gap;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic [31:0]   pkt_count;

  pktunit_axis_arbiter_if #(.DATA_BYTES(DATA_BYTES), .LANES(NUM_PORTS)) s_bus ();
  pktunit_axis_arbiter_if #(.DATA_BYTES(DATA_BYTES), .LANES(1))         m_bus ();

  pktunit_axis_arbiter #(.DATA_BYTES(DATA_BYTES), .NUM_PORTS(NUM_PORTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s_bus),
    .m         (m_bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int    tests_run = 0;
  int    failures  = 0;
  int    out_beats = 0;
  beat_t tx_q[NUM_PORTS][$];
  beat_t exp_q[$];
  bit    rdy_q[$];
  int    grant_log[$];
  logic [NUM_PORTS-1:0] fired;
  bit    stalled;
  bit    prev_busy;
  bit    chk_ready;
  logic [63:0] held_data;
  logic [7:0]  held_flags;
  logic [7:0]  held_eop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one packet on a source; its beats are expected on the output in call order.
  task automatic applyStimulus(input int port, input int id, input int n, input logic [7:0] last_eop,
                               input int gap_mask, input int gap_len);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data  = {8'(port), 8'(id), 16'(k), $urandom()};
      b.flags = 8'($urandom());
      b.eop   = (k == n - 1) ? last_eop : 8'h00;
      b.gap   = gap_mask[k] ? gap_len : 0;
      tx_q[port].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic flush_queues();
    for (int i = 0; i < NUM_PORTS; i++) tx_q[i].delete();
    exp_q.delete();
    rdy_q.delete();
    grant_log.delete();
    out_beats = 0;
  endtask

  // Entered and left 3 time units after a rising edge, away from the engine's activity.
  task automatic do_reset();
    rst = 1'b1;
    flush_queues();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit pending;
    for (int c = 0; c < 400; c++) begin
      pending = (exp_q.size() != 0);
      for (int i = 0; i < NUM_PORTS; i++) if (tx_q[i].size() != 0) pending = 1'b1;
      if (!pending) break;
      @(posedge clk);
    end
    checkOutput({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
  endtask

  // Monitor at the falling edge, drive sources and the sink ready just after the rising edge.
  always begin
    logic  mready;
    beat_t e;
    logic [NUM_PORTS-1:0] v;
    @(negedge clk);
    if (rst) begin
      stalled   = 1'b0;
      prev_busy = 1'b0;
      fired     = '0;
    end else begin
      mready = m_bus.data_r[0] & m_bus.flags_r[0] & m_bus.eop_r[0];
      if (stalled) begin
        checkOutput("hold_valid", 64'(m_bus.data_v[0]), 64'd1);
        checkOutput("hold_data",  m_bus.data_d, held_data);
        checkOutput("hold_flags", 64'(m_bus.flags_d), 64'(held_flags));
        checkOutput("hold_eop",   64'(m_bus.eop_d), 64'(held_eop));
      end
      if (m_bus.data_v[0] && mready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          out_beats++;
          checkOutput("beat_data",  m_bus.data_d, e.data);
          checkOutput("beat_flags", 64'(m_bus.flags_d), 64'(e.flags));
          checkOutput("beat_eop",   64'(m_bus.eop_d), 64'(e.eop));
        end
      end
      stalled    = m_bus.data_v[0] && !mready;
      held_data  = m_bus.data_d;
      held_flags = m_bus.flags_d;
      held_eop   = m_bus.eop_d;
      if (chk_ready && busy) begin
        checkOutput("ready_rule",   64'(s_bus.data_r[1]), 64'(!m_bus.data_v[0] || mready));
        checkOutput("ready_others", 64'(s_bus.data_r & 4'b1101), 64'd0);
      end
      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;
      for (int i = 0; i < NUM_PORTS; i++) fired[i] = s_bus.data_v[i] & s_bus.data_r[i];
    end
    @(posedge clk);
    #1;
    v = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (fired[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
      if (tx_q[i].size() > 0 && tx_q[i][0].gap > 0) begin
        tx_q[i][0].gap = tx_q[i][0].gap - 1;
      end else if (tx_q[i].size() > 0) begin
        v[i] = 1'b1;
        s_bus.data_d[i*64 +: 64]        = tx_q[i][0].data;
        s_bus.flags_d[i*8 +: 8]         = tx_q[i][0].flags;
        s_bus.eop_d[i*DATA_BYTES +: DATA_BYTES] = tx_q[i][0].eop;
      end
    end
    fired         = '0;
    s_bus.data_v  = v;
    s_bus.flags_v = v;
    s_bus.eop_v   = v;
    m_bus.data_r  = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int order2[6];
    order2 = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1;
    chk_ready = 1'b0;
    fired = '0;
    s_bus.data_d = '0; s_bus.flags_d = '0; s_bus.eop_d = '0;
    s_bus.data_v = '0; s_bus.flags_v = '0; s_bus.eop_v = '0;
    m_bus.data_r = 1'b1; m_bus.flags_r = 1'b1; m_bus.eop_r = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    checkOutput("rst_grant",  64'(grant_id), 64'd3);
    checkOutput("rst_busy",   64'(busy), 64'd0);
    checkOutput("rst_count",  64'(pkt_count), 64'd0);
    checkOutput("rst_mvalid", 64'(m_bus.data_v), 64'd0);
    checkOutput("rst_sready", 64'(s_bus.data_r), 64'd0);
    checkOutput("rst_mdata",  m_bus.data_d, 64'd0);
    checkOutput("rst_meop",   64'(m_bus.eop_d), 64'd0);
    rst = 1'b0;

    $display("[TB] single 3-beat packet on port 2");
    applyStimulus(2, 1, 3, 8'h07, 0, 0);
    wait_drain("t1");
    checkOutput("t1_grant", 64'(grant_id), 64'd2);
    checkOutput("t1_count", 64'(pkt_count), 64'd1);
    checkOutput("t1_busy",  64'(busy), 64'd0);
    checkOutput("t1_grants", 64'(grant_log.size()), 64'd1);

    $display("[TB] all ports contending with 2-beat packets");
    do_reset();
    applyStimulus(0, 10, 2, 8'hFF, 0, 0);
    applyStimulus(1, 11, 2, 8'h01, 0, 0);
    applyStimulus(2, 12, 2, 8'h03, 0, 0);
    applyStimulus(3, 13, 2, 8'h80, 0, 0);
    applyStimulus(0, 14, 2, 8'h0F, 0, 0);
    applyStimulus(1, 15, 2, 8'hFF, 0, 0);
    wait_drain("t2");
    checkOutput("t2_count", 64'(pkt_count), 64'd6);
    checkOutput("t2_grants", 64'(grant_log.size()), 64'd6);
    for (int k = 0; k < 6; k++)
      checkOutput("t2_order", (k < grant_log.size()) ? 64'(grant_log[k]) : 64'hF, 64'(order2[k]));

    $display("[TB] port 1 with sink backpressure");
    do_reset();
    chk_ready = 1'b1;
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(1, 20, 4, 8'h01, 0, 0);
    wait_drain("t3");
    chk_ready = 1'b0;
    checkOutput("t3_count", 64'(pkt_count), 64'd1);

    $display("[TB] port 0 valid gaps while port 3 waits");
    do_reset();
    applyStimulus(0, 30, 5, 8'h80, 32'b01010, 3);
    applyStimulus(3, 31, 1, 8'hFF, 0, 0);
    wait_drain("t4");
    checkOutput("t4_grants", 64'(grant_log.size()), 64'd2);
    checkOutput("t4_first",  (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hF, 64'd0);
    checkOutput("t4_second", (grant_log.size() > 1) ? 64'(grant_log[1]) : 64'hF, 64'd3);
    checkOutput("t4_count", 64'(pkt_count), 64'd2);

    $display("[TB] reset in the middle of a 5-beat packet");
    do_reset();
    applyStimulus(1, 40, 5, 8'hFF, 0, 0);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (out_beats >= 2) break;
    end
    checkOutput("t5_beats_before_rst", 64'(out_beats), 64'd2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_mvalid", 64'(m_bus.data_v), 64'd0);
    checkOutput("t5_busy",   64'(busy), 64'd0);
    checkOutput("t5_count",  64'(pkt_count), 64'd0);
    checkOutput("t5_grant",  64'(grant_id), 64'd3);
    checkOutput("t5_sready", 64'(s_bus.data_r), 64'd0);
    checkOutput("t5_mdata",  m_bus.data_d, 64'd0);
    checkOutput("t5_mflags", 64'(m_bus.flags_d), 64'd0);
    flush_queues();
    @(posedge clk);
    #3;
    rst = 1'b0;
    applyStimulus(0, 41, 1, 8'h01, 0, 0);
    applyStimulus(2, 42, 1, 8'h01, 0, 0);
    wait_drain("t5");
    checkOutput("t5_next_grant", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hF, 64'd0);
    checkOutput("t5_count_after", 64'(pkt_count), 64'd2);

    $display("[TB] packet counter wrap");
    do_reset();
    force dut.pkt_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #3;
    release dut.pkt_count;
    checkOutput("t6_preload", 64'(pkt_count), 64'hFFFF_FFFF);
    applyStimulus(3, 50, 1, 8'h01, 0, 0);
    wait_drain("t6");
    checkOutput("t6_wrap", 64'(pkt_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
